// File: rtl/cmp_event_monitor_if.sv
// Sample/status bundle between a comparator front end and cmp_event_monitor.
// master drives samples and clear; slave (the monitor) drives the registered status.
interface cmp_event_monitor_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_g;
    logic             in_e;
    logic             in_l;
    logic             clear;
    logic             alarm;
    logic             trip;
    logic [1:0]       state;
    logic [CNT_W-1:0] g_cnt;
    logic [CNT_W-1:0] e_cnt;
    logic [CNT_W-1:0] l_cnt;
    logic             bad_code;

    modport master (
        output in_valid, in_g, in_e, in_l, clear,
        input  alarm, trip, state, g_cnt, e_cnt, l_cnt, bad_code
    );

    modport slave (
        input  in_valid, in_g, in_e, in_l, clear,
        output alarm, trip, state, g_cnt, e_cnt, l_cnt, bad_code
    );
endinterface

// File: rtl/cmp_event_monitor.sv
// Qualifies a one-hot g/e/l compare stream: saturating event counts plus hysteretic alarm FSM.
// Latency: one cycle, all outputs registered. No backpressure: every valid sample is consumed.
// Optional CMP_MON_STICKY_ALARM_EN: alarm latches on trip and holds until clear or reset.
module cmp_event_monitor #(
    parameter int TRIP_COUNT    = 4,
    parameter int RELEASE_COUNT = 3,
    parameter int CNT_W         = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    cmp_event_monitor_if.slave  mon
);
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ARMING    = 2'd1,
        S_ALARM     = 2'd2,
        S_RELEASING = 2'd3
    } state_t;

    localparam logic [3:0]       TRIP_N = 4'(TRIP_COUNT);
    localparam logic [3:0]       REL_N  = 4'(RELEASE_COUNT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [3:0]       run_q, run_d;
    logic [CNT_W-1:0] g_q, g_d, e_q, e_d, l_q, l_d;
    logic             trip_q, trip_d;
    logic             bad_q, bad_d;
    logic             alarm_q, alarm_d;
    logic             one_hot;

    assign one_hot = (mon.in_g & ~mon.in_e & ~mon.in_l) |
                     (~mon.in_g & mon.in_e & ~mon.in_l) |
                     (~mon.in_g & ~mon.in_e & mon.in_l);

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        g_d     = g_q;
        e_d     = e_q;
        l_d     = l_q;
        trip_d  = 1'b0;
        bad_d   = 1'b0;
        if (mon.clear) begin
            state_d = S_IDLE;
            run_d   = '0;
            g_d     = '0;
            e_d     = '0;
            l_d     = '0;
        end else if (mon.in_valid) begin
            if (!one_hot) begin
                bad_d = 1'b1;
            end else begin
                if (mon.in_g && g_q != CNT_MAX) g_d = g_q + 1'b1;
                if (mon.in_e && e_q != CNT_MAX) e_d = e_q + 1'b1;
                if (mon.in_l && l_q != CNT_MAX) l_d = l_q + 1'b1;
                case (state_q)
                    S_IDLE: begin
                        if (mon.in_g) begin
                            if (TRIP_N == 4'd1) begin
                                state_d = S_ALARM;
                                run_d   = '0;
                                trip_d  = 1'b1;
                            end else begin
                                state_d = S_ARMING;
                                run_d   = 4'd1;
                            end
                        end
                    end
                    S_ARMING: begin
                        if (mon.in_g) begin
                            if (run_q + 4'd1 == TRIP_N) begin
                                state_d = S_ALARM;
                                run_d   = '0;
                                trip_d  = 1'b1;
                            end else begin
                                run_d = run_q + 4'd1;
                            end
                        end else begin
                            state_d = S_IDLE;
                            run_d   = '0;
                        end
                    end
                    S_ALARM: begin
                        if (mon.in_l) begin
                            if (REL_N == 4'd1) begin
                                state_d = S_IDLE;
                                run_d   = '0;
                            end else begin
                                state_d = S_RELEASING;
                                run_d   = 4'd1;
                            end
                        end
                    end
                    S_RELEASING: begin
                        if (mon.in_l) begin
                            if (run_q + 4'd1 == REL_N) begin
                                state_d = S_IDLE;
                                run_d   = '0;
                            end else begin
                                run_d = run_q + 4'd1;
                            end
                        end else if (mon.in_g) begin
                            // Re-entry from RELEASING is not a new trip.
                            state_d = S_ALARM;
                            run_d   = '0;
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                        run_d   = '0;
                    end
                endcase
            end
        end
    end

`ifdef CMP_MON_STICKY_ALARM_EN
    assign alarm_d = mon.clear ? 1'b0 : (alarm_q | trip_d);
`else
    assign alarm_d = (state_d == S_ALARM) || (state_d == S_RELEASING);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            run_q   <= '0;
            g_q     <= '0;
            e_q     <= '0;
            l_q     <= '0;
            trip_q  <= 1'b0;
            bad_q   <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            g_q     <= g_d;
            e_q     <= e_d;
            l_q     <= l_d;
            trip_q  <= trip_d;
            bad_q   <= bad_d;
            alarm_q <= alarm_d;
        end
    end

    assign mon.state    = state_q;
    assign mon.alarm    = alarm_q;
    assign mon.trip     = trip_q;
    assign mon.bad_code = bad_q;
    assign mon.g_cnt    = g_q;
    assign mon.e_cnt    = e_q;
    assign mon.l_cnt    = l_q;
endmodule

// File: tb/tb_cmp_event_monitor.sv
// Directed bench for cmp_event_monitor with default parameters (TRIP 4, RELEASE 3, CNT_W 8).
module tb_cmp_event_monitor;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    cmp_event_monitor_if #(.CNT_W(8)) mon_if ();

    cmp_event_monitor #(
        .TRIP_COUNT   (4),
        .RELEASE_COUNT(3),
        .CNT_W        (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .mon  (mon_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: drive at negedge, let the posedge take it, return 1 unit after the edge.
    task automatic step(input logic v, input logic g, input logic e, input logic l, input logic clr);
        @(negedge clk);
        mon_if.in_valid = v;
        mon_if.in_g     = g;
        mon_if.in_e     = e;
        mon_if.in_l     = l;
        mon_if.clear    = clr;
        @(posedge clk);
        #1;
        mon_if.in_valid = 1'b0;
        mon_if.in_g     = 1'b0;
        mon_if.in_e     = 1'b0;
        mon_if.in_l     = 1'b0;
        mon_if.clear    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mon_if.in_valid = 1'b0;
        mon_if.in_g = 1'b0;
        mon_if.in_e = 1'b0;
        mon_if.in_l = 1'b0;
        mon_if.clear = 1'b0;
        #3;
        checks++;
        if ({mon_if.state, mon_if.alarm, mon_if.trip, mon_if.bad_code} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b exp 00000",
                     {mon_if.state, mon_if.alarm, mon_if.trip, mon_if.bad_code});
        end
        checks++;
        if ({mon_if.g_cnt, mon_if.e_cnt, mon_if.l_cnt} !== 24'h0) begin
            errors++;
            $display("FAIL reset_cnts: got %h exp 000000", {mon_if.g_cnt, mon_if.e_cnt, mon_if.l_cnt});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_trip();
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
        checks++;
        if ({mon_if.state, mon_if.alarm, mon_if.trip} !== {2'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL trip_arming: got %b exp 0100", {mon_if.state, mon_if.alarm, mon_if.trip});
        end
        step(1, 1, 0, 0, 0);
        checks++;
        if ({mon_if.state, mon_if.alarm, mon_if.trip} !== {2'd2, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL trip_fire: got %b exp 1011", {mon_if.state, mon_if.alarm, mon_if.trip});
        end
        checks++;
        if (mon_if.g_cnt !== 8'd4) begin
            errors++;
            $display("FAIL trip_gcnt: got %0d exp 4", mon_if.g_cnt);
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if ({mon_if.state, mon_if.alarm, mon_if.trip} !== {2'd2, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL trip_one_cycle: got %b exp 1010", {mon_if.state, mon_if.alarm, mon_if.trip});
        end
    endtask

    task automatic test_abort_and_gaps();
        step(1, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        checks++;
        if ({mon_if.state, mon_if.alarm, mon_if.trip} !== 4'b0000) begin
            errors++;
            $display("FAIL abort_state: got %b exp 0000", {mon_if.state, mon_if.alarm, mon_if.trip});
        end
        checks++;
        if ({mon_if.g_cnt, mon_if.e_cnt} !== {8'd3, 8'd1}) begin
            errors++;
            $display("FAIL abort_cnts: got g=%0d e=%0d exp g=3 e=1", mon_if.g_cnt, mon_if.e_cnt);
        end
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        checks++;
        if ({mon_if.state, mon_if.trip} !== {2'd1, 1'b0}) begin
            errors++;
            $display("FAIL gap_arming: got %b exp 010", {mon_if.state, mon_if.trip});
        end
        step(1, 1, 0, 0, 0);
        checks++;
        if ({mon_if.state, mon_if.alarm, mon_if.trip, mon_if.g_cnt} !== {2'd2, 1'b1, 1'b1, 8'd7}) begin
            errors++;
            $display("FAIL gap_trip: got st=%0d al=%b tr=%b g=%0d exp st=2 al=1 tr=1 g=7",
                     mon_if.state, mon_if.alarm, mon_if.trip, mon_if.g_cnt);
        end
    endtask

    task automatic test_release();
        logic [1:0] exp_st [4];
        logic       exp_al [4];
        logic [2:0] pat    [4];
        exp_st = '{2'd3, 2'd3, 2'd3, 2'd0};
        exp_al = '{1'b1, 1'b1, 1'b1, 1'b0};
        pat    = '{3'b001, 3'b001, 3'b010, 3'b001};
        for (int i = 0; i < 4; i++) begin
            step(1, pat[i][2], pat[i][1], pat[i][0], 0);
            checks++;
            if ({mon_if.state, mon_if.alarm, mon_if.trip} !== {exp_st[i], exp_al[i], 1'b0}) begin
                errors++;
                $display("FAIL release_%0d: got st=%0d al=%b tr=%b exp st=%0d al=%b tr=0",
                         i, mon_if.state, mon_if.alarm, mon_if.trip, exp_st[i], exp_al[i]);
            end
        end
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        checks++;
        if (mon_if.state !== 2'd3) begin
            errors++;
            $display("FAIL rearm_releasing: got %0d exp 3", mon_if.state);
        end
        step(1, 1, 0, 0, 0);
        checks++;
        if ({mon_if.state, mon_if.alarm, mon_if.trip} !== {2'd2, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rearm_no_trip: got %b exp 1010", {mon_if.state, mon_if.alarm, mon_if.trip});
        end
    endtask

    task automatic test_bad_code();
        step(1, 1, 0, 1, 0);
        checks++;
        if ({mon_if.bad_code, mon_if.state} !== {1'b1, 2'd2}) begin
            errors++;
            $display("FAIL bad_gl: got bad=%b st=%0d exp bad=1 st=2", mon_if.bad_code, mon_if.state);
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if (mon_if.bad_code !== 1'b0) begin
            errors++;
            $display("FAIL bad_pulse: got %b exp 0", mon_if.bad_code);
        end
        step(1, 0, 0, 0, 0);
        checks++;
        if ({mon_if.bad_code, mon_if.state} !== {1'b1, 2'd2}) begin
            errors++;
            $display("FAIL bad_none: got bad=%b st=%0d exp bad=1 st=2", mon_if.bad_code, mon_if.state);
        end
        checks++;
        if ({mon_if.g_cnt, mon_if.e_cnt, mon_if.l_cnt} !== {8'd12, 8'd2, 8'd4}) begin
            errors++;
            $display("FAIL bad_cnts: got g=%0d e=%0d l=%0d exp g=12 e=2 l=4",
                     mon_if.g_cnt, mon_if.e_cnt, mon_if.l_cnt);
        end
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_clear();
        step(1, 1, 0, 0, 1);
        checks++;
        if ({mon_if.state, mon_if.alarm, mon_if.trip, mon_if.bad_code} !== 5'b0) begin
            errors++;
            $display("FAIL clear_flags: got %b exp 00000",
                     {mon_if.state, mon_if.alarm, mon_if.trip, mon_if.bad_code});
        end
        checks++;
        if ({mon_if.g_cnt, mon_if.e_cnt, mon_if.l_cnt} !== 24'h0) begin
            errors++;
            $display("FAIL clear_cnts: got %h exp 000000", {mon_if.g_cnt, mon_if.e_cnt, mon_if.l_cnt});
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 255; i++) step(1, 0, 1, 0, 0);
        checks++;
        if (mon_if.e_cnt !== 8'd255) begin
            errors++;
            $display("FAIL sat_reach: got %0d exp 255", mon_if.e_cnt);
        end
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0);
        checks++;
        if ({mon_if.e_cnt, mon_if.g_cnt, mon_if.state} !== {8'd255, 8'd0, 2'd0}) begin
            errors++;
            $display("FAIL sat_hold: got e=%0d g=%0d st=%0d exp e=255 g=0 st=0",
                     mon_if.e_cnt, mon_if.g_cnt, mon_if.state);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mon_if.state, mon_if.alarm, mon_if.trip} !== 4'b0000) begin
            errors++;
            $display("FAIL arst_trip: got %b exp 0000", {mon_if.state, mon_if.alarm, mon_if.trip});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mon_if.state, mon_if.alarm, mon_if.trip, mon_if.bad_code,
             mon_if.g_cnt, mon_if.e_cnt, mon_if.l_cnt} !== 29'h0) begin
            errors++;
            $display("FAIL arst_releasing: got st=%0d al=%b g=%0d l=%0d exp all 0",
                     mon_if.state, mon_if.alarm, mon_if.g_cnt, mon_if.l_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sticky();
        logic exp_al;
`ifdef CMP_MON_STICKY_ALARM_EN
        exp_al = 1'b1;
`else
        exp_al = 1'b0;
`endif
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0);
        checks++;
        if ({mon_if.state, mon_if.alarm} !== {2'd0, exp_al}) begin
            errors++;
            $display("FAIL sticky_after_release: got st=%0d al=%b exp st=0 al=%b",
                     mon_if.state, mon_if.alarm, exp_al);
        end
        step(0, 0, 0, 0, 1);
        checks++;
        if (mon_if.alarm !== 1'b0) begin
            errors++;
            $display("FAIL sticky_clear: got %b exp 0", mon_if.alarm);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_trip();
        test_abort_and_gaps();
        test_release();
        test_bad_code();
        test_clear();
        test_saturation();
        test_async_reset();
        test_sticky();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cmp_event_monitor.md
Name: cmp_event_monitor

Overview:
- Downstream consumer of the 4-bit magnitude comparator's one-hot g/e/l result.
- Qualifies the raw compare stream over time: saturating per-outcome event counts plus a hysteretic alarm.
- Alarm trips after TRIP_COUNT consecutive "greater" samples and releases after RELEASE_COUNT consecutive "less" samples.
- Feeds status/interrupt logic; all outputs registered.

Parameters:
TRIP_COUNT, 4, consecutive valid g samples needed to trip alarm; legal 1..15
RELEASE_COUNT, 3, consecutive valid l samples needed to release alarm; legal 1..15
CNT_W, 8, width of each saturating event counter; legal 2..16

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  g/e/l sample qualifier
in_g  input  1  comparator a>b
in_e  input  1  comparator a==b
in_l  input  1  comparator a<b
clear  input  1  synchronous clear of state and counters
alarm  output  1  alarm level
trip  output  1  one-cycle pulse on entry to ALARM
state  output  2  FSM state: 0 IDLE, 1 ARMING, 2 ALARM, 3 RELEASING
g_cnt  output  CNT_W  saturating count of valid g samples
e_cnt  output  CNT_W  saturating count of valid e samples
l_cnt  output  CNT_W  saturating count of valid l samples
bad_code  output  1  one-cycle pulse when a valid sample is not exactly one-hot

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0; state IDLE; internal 4-bit run counter 0. Reset mid-operation aborts immediately, with no residual pulse.
- Latency: a sample accepted at edge N is reflected in all outputs after edge N (one cycle).
- in_valid low: no state, run, or counter change. Gaps do not break a consecutive run.
- Legal sample: exactly one of in_g/in_e/in_l high.
  - Illegal valid sample (0 or ≥2 bits high): bad_code=1 for one cycle; state, run and counters unchanged.
- Counters: increment the matching counter on each legal valid sample; saturate at 2^CNT_W-1 with no wrap.
- Priority: rst_n > clear > sample.
  - clear=1: state IDLE, run 0, all counters 0, trip 0, bad_code 0. Any concurrent sample is discarded.
- FSM (legal valid samples only):
  - IDLE:
    - g: go to ALARM if TRIP_COUNT==1, else ARMING with run=1.
    - e or l: stay IDLE.
  - ARMING:
    - g: run+1. When run+1==TRIP_COUNT, go to ALARM with run=0.
    - e or l: go to IDLE with run=0.
  - ALARM:
    - l: go to IDLE if RELEASE_COUNT==1, else RELEASING with run=1.
    - g or e: stay ALARM.
  - RELEASING:
    - l: run+1. When run+1==RELEASE_COUNT, go to IDLE with run=0.
    - g: go to ALARM with run=0 (no trip pulse).
    - e: stay RELEASING; run holds.
- alarm=1 exactly while state is ALARM or RELEASING (when the optional feature is absent).
- trip=1 for one cycle only on IDLE→ALARM or ARMING→ALARM.
- Unreachable encodings are not possible with a 2-bit state. Any corrupted value recovers to IDLE on the next valid sample.

Optional Feature:
- Macro: CMP_MON_STICKY_ALARM_EN
- Defined: alarm is a sticky flag. It is set on any trip and stays 1 until clear or reset, even after the FSM returns to IDLE. The FSM, trip, and counters behave identically.
- Undefined: alarm follows state as described in Behaviour.

Test Plan:
1. Defaults; rst_n released, then g,g,g,g valid on consecutive cycles -> after the 4th edge: state=2, alarm=1, trip=1 for exactly one cycle, g_cnt=4.
2. g,g,g,e -> state returns to 0, alarm stays 0, no trip, g_cnt=3, e_cnt=1. Then g,idle,g,idle,g,g (in_valid gaps) -> trip after the 4th g.
3. From ALARM: l,l,e,l -> state 3,3,3,0. alarm falls only after the final l. Then ALARM,l,g -> state 3 then 2, no trip pulse.
4. Valid samples {g=1,l=1} and {0,0,0} -> bad_code pulses twice; counters and state unchanged.
5. clear asserted with a concurrent valid g while in ALARM -> next cycle state=0, alarm=0, all counts 0, trip=0. Separately, 260 valid e samples with CNT_W=8 -> e_cnt holds 255.
6. rst_n pulled low asynchronously mid-RELEASING, between edges -> all outputs 0 before the next edge. With CMP_MON_STICKY_ALARM_EN: trip then release -> alarm stays 1 until clear.
